// File: rtl/universal_register.sv
// Multi-mode WIDTH-bit register: load/clear/inc/dec in one cycle, shift/rotate one bit per clock.
// Define UR_SATURATE_EN to make increment/decrement saturate instead of wrapping.
module universal_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [AMT_W-1:0] Amount,
  input  logic [WIDTH-1:0] Input,
  input  logic             SerialIn,
  output logic [WIDTH-1:0] Output,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_CLR  = 3'b010;
  localparam logic [2:0] M_INC  = 3'b011;
  localparam logic [2:0] M_DEC  = 3'b100;
  localparam logic [2:0] M_SHL  = 3'b101;
  localparam logic [2:0] M_SHR  = 3'b110;
  localparam logic [2:0] M_ROL  = 3'b111;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_s;
  logic             launch_s;
  logic [WIDTH:0]   step_s;

  // One-bit move for the latched shift mode: {bit moved out, new data}.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0] m,
                                                input logic [WIDTH-1:0] d,
                                                input logic si);
    case (m)
      M_SHL:   return {d[WIDTH-1], d[WIDTH-2:0], si};
      M_SHR:   return {d[0], si, d[WIDTH-1:1]};
      M_ROL:   return {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      default: return {1'b0, d};
    endcase
  endfunction

  assign accept_s = Start && (state_q == S_IDLE);
  assign launch_s = accept_s && (Mode >= M_SHL) && (Amount != {AMT_W{1'b0}});
  assign step_s   = shift_step(mode_q, data_q, SerialIn);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      mode_q  <= M_HOLD;
      cnt_q   <= {AMT_W{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: enter SHIFT on a non-zero shift command, leave after the last bit.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (launch_s) begin
          state_d = S_SHIFT;
          mode_d  = Mode;
          cnt_d   = Amount;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q <= AMT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = {AMT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q - AMT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {AMT_W{1'b0}};
      end
    endcase
  end

  // Output/datapath logic: single-cycle ops on accept, one shift step per SHIFT cycle.
  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    busy_d  = (state_d == S_SHIFT);
    if (state_q == S_SHIFT) begin
      {carry_d, data_d} = step_s;
      done_d = (state_d == S_IDLE);
    end else if (accept_s) begin
      done_d = !launch_s;
      case (Mode)
        M_LOAD: begin
          data_d  = Input;
          carry_d = 1'b0;
        end
        M_CLR: begin
          data_d  = {WIDTH{1'b0}};
          carry_d = 1'b0;
        end
        M_INC: begin
`ifdef UR_SATURATE_EN
          if (&data_q) begin
            data_d  = data_q;
            carry_d = 1'b1;
          end else begin
            data_d  = data_q + WIDTH'(1);
            carry_d = 1'b0;
          end
`else
          data_d  = data_q + WIDTH'(1);
          carry_d = &data_q;
`endif
        end
        M_DEC: begin
`ifdef UR_SATURATE_EN
          if (data_q == {WIDTH{1'b0}}) begin
            data_d  = data_q;
            carry_d = 1'b1;
          end else begin
            data_d  = data_q - WIDTH'(1);
            carry_d = 1'b0;
          end
`else
          data_d  = data_q - WIDTH'(1);
          carry_d = (data_q == {WIDTH{1'b0}});
`endif
        end
        default: begin
          // Hold, and shift commands whose bits move in later SHIFT cycles (or not at all for k=0).
          data_d  = data_q;
          carry_d = carry_q;
        end
      endcase
    end else begin
      data_d  = data_q;
      carry_d = carry_q;
    end
  end

  assign Output   = data_q;
  assign CarryOut = carry_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Zero     = (data_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_register.sv
// Directed self-checking bench for universal_register (WIDTH=8, AMT_W=4).
module tb_universal_register;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [2:0] Mode;
  logic [3:0] Amount;
  logic [7:0] Input;
  logic       SerialIn;
  logic [7:0] Output;
  logic       CarryOut;
  logic       Zero;
  logic       Busy;
  logic       Done;

  int tests = 0;
  int fails = 0;

`ifdef UR_SATURATE_EN
  localparam logic [7:0] INC_TOP = 8'hFF;
  localparam logic [7:0] DEC_BOT = 8'h00;
  localparam logic       INC_Z   = 1'b0;
`else
  localparam logic [7:0] INC_TOP = 8'h00;
  localparam logic [7:0] DEC_BOT = 8'hFF;
  localparam logic       INC_Z   = 1'b1;
`endif

  universal_register #(.WIDTH(8), .AMT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Amount(Amount),
    .Input(Input), .SerialIn(SerialIn), .Output(Output), .CarryOut(CarryOut),
    .Zero(Zero), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d);
    Start = 1'b1; Mode = m; Amount = a; Input = d;
    tick();
    Start = 1'b0; Mode = 3'b000; Amount = 4'd0; Input = 8'h5A;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Mode = 3'b000; Amount = 4'd0; Input = 8'h00; SerialIn = 1'b0;
    @(negedge Clk);
    tick();
    Reset = 1'b0;
    chk8("rst_out", Output, 8'h00);
    chk1("rst_zero", Zero, 1'b1);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_carry", CarryOut, 1'b0);

    // Load
    op(3'b001, 4'd0, 8'hA5);
    chk8("load_out", Output, 8'hA5);
    chk1("load_done", Done, 1'b1);
    chk1("load_busy", Busy, 1'b0);
    chk1("load_zero", Zero, 1'b0);
    tick();
    chk1("load_done_clr", Done, 1'b0);
    chk1("load_busy2", Busy, 1'b0);

    // Increment wrap / saturate, then hold keeps carry
    op(3'b001, 4'd0, 8'hFF);
    op(3'b011, 4'd0, 8'h00);
    chk8("inc_wrap_out", Output, INC_TOP);
    chk1("inc_wrap_carry", CarryOut, 1'b1);
    chk1("inc_wrap_zero", Zero, INC_Z);
    chk1("inc_wrap_done", Done, 1'b1);
    op(3'b000, 4'd0, 8'h33);
    chk8("hold_out", Output, INC_TOP);
    chk1("hold_carry", CarryOut, 1'b1);
    chk1("hold_done", Done, 1'b1);

    // Decrement wrap / saturate
    op(3'b001, 4'd0, 8'h00);
    op(3'b100, 4'd0, 8'h00);
    chk8("dec_wrap_out", Output, DEC_BOT);
    chk1("dec_wrap_carry", CarryOut, 1'b1);

    // Ordinary inc/dec/clear
    op(3'b001, 4'd0, 8'h41);
    op(3'b011, 4'd0, 8'h00);
    chk8("inc_out", Output, 8'h42);
    chk1("inc_carry", CarryOut, 1'b0);
    op(3'b100, 4'd0, 8'h00);
    chk8("dec_out", Output, 8'h41);
    chk1("dec_carry", CarryOut, 1'b0);
    op(3'b010, 4'd0, 8'h00);
    chk8("clr_out", Output, 8'h00);
    chk1("clr_zero", Zero, 1'b1);

    // Shift left by 3 with SerialIn=1, ignored Start while busy, accepted Start in Done cycle
    op(3'b001, 4'd0, 8'h81);
    SerialIn = 1'b1;
    op(3'b101, 4'd3, 8'h00);
    chk1("shl_busy0", Busy, 1'b1);
    chk1("shl_done0", Done, 1'b0);
    chk8("shl_out0", Output, 8'h81);
    Start = 1'b1; Mode = 3'b010;
    tick();
    Start = 1'b0; Mode = 3'b000;
    chk8("shl_out1", Output, 8'h03);
    chk1("shl_carry1", CarryOut, 1'b1);
    chk1("shl_busy1", Busy, 1'b1);
    tick();
    chk8("shl_out2", Output, 8'h07);
    chk1("shl_carry2", CarryOut, 1'b0);
    chk1("shl_busy2", Busy, 1'b1);
    chk1("shl_done2", Done, 1'b0);
    tick();
    chk8("shl_out3", Output, 8'h0F);
    chk1("shl_carry3", CarryOut, 1'b0);
    chk1("shl_busy3", Busy, 1'b0);
    chk1("shl_done3", Done, 1'b1);
    op(3'b010, 4'd0, 8'h00);
    chk8("b2b_clr_out", Output, 8'h00);
    chk1("b2b_clr_done", Done, 1'b1);
    chk1("b2b_clr_busy", Busy, 1'b0);

    // Shift right logical by 2 with SerialIn=0
    SerialIn = 1'b0;
    op(3'b001, 4'd0, 8'h81);
    op(3'b110, 4'd2, 8'h00);
    tick();
    chk8("shr_out1", Output, 8'h40);
    chk1("shr_carry1", CarryOut, 1'b1);
    tick();
    chk8("shr_out2", Output, 8'h20);
    chk1("shr_carry2", CarryOut, 1'b0);
    chk1("shr_done", Done, 1'b1);

    // Rotate past width
    op(3'b001, 4'd0, 8'h01);
    op(3'b111, 4'd9, 8'h00);
    repeat (8) tick();
    chk8("rol9_out8", Output, 8'h01);
    chk1("rol9_busy8", Busy, 1'b1);
    tick();
    chk8("rol9_out", Output, 8'h02);
    chk1("rol9_carry", CarryOut, 1'b0);
    chk1("rol9_busy", Busy, 1'b0);
    chk1("rol9_done", Done, 1'b1);

    // Rotate carry, then Amount=0 leaves data and carry alone
    op(3'b001, 4'd0, 8'h80);
    op(3'b111, 4'd1, 8'h00);
    chk1("rol1_busy", Busy, 1'b1);
    tick();
    chk8("rol1_out", Output, 8'h01);
    chk1("rol1_carry", CarryOut, 1'b1);
    op(3'b111, 4'd0, 8'h00);
    chk8("amt0_out", Output, 8'h01);
    chk1("amt0_carry", CarryOut, 1'b1);
    chk1("amt0_done", Done, 1'b1);
    chk1("amt0_busy", Busy, 1'b0);
    tick();
    chk1("amt0_done_clr", Done, 1'b0);
    chk1("amt0_busy2", Busy, 1'b0);

    // Logical shift beyond width fills entirely with SerialIn
    op(3'b001, 4'd0, 8'hFF);
    op(3'b101, 4'd10, 8'h00);
    repeat (10) tick();
    chk8("shl10_out", Output, 8'h00);
    chk1("shl10_zero", Zero, 1'b1);
    chk1("shl10_carry", CarryOut, 1'b0);
    chk1("shl10_done", Done, 1'b1);

    // Reset at the 2nd shift edge
    op(3'b001, 4'd0, 8'hF0);
    op(3'b101, 4'd5, 8'h00);
    tick();
    chk8("mid_out1", Output, 8'hE0);
    chk1("mid_carry1", CarryOut, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk8("mid_rst_out", Output, 8'h00);
    chk1("mid_rst_busy", Busy, 1'b0);
    chk1("mid_rst_done", Done, 1'b0);
    chk1("mid_rst_carry", CarryOut, 1'b0);
    chk1("mid_rst_zero", Zero, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("mid_no_done", Done, 1'b0);
      chk1("mid_no_busy", Busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
